diad_trace_buffer: RTL and testbench
====================================

Name: diad_trace_buffer

Overview:
Synthesizable on-chip trace capture for the diad pipeline. It is the hardware successor to the simulation-only per-stage $display debug dumps. Each capture cycle it snapshots NCH pipeline-stage probe words (e.g. IA..RO PCs or instrs) plus a cycle tick into a circular RAM. It supports trigger-with-post-count and one-shot modes, and a random-access readout port for a debug host.

Parameters:
DATA_W, 24, width of one probe channel word
NCH, 7, number of probe channels (pipeline stages)
DEPTH, 16, entries in trace RAM; power of 2, >=2
TICK_W, 16, width of free-running tick stamp
TRIG_CH, 0, channel index compared against iw_trig_val

Ports:
iw_clk  in  1  clock, all logic rising-edge
iw_rst_n  in  1  asynchronous active-low reset
iw_probe  in  NCH*DATA_W  probe words; channel k at [k*DATA_W +: DATA_W]
iw_cap_en  in  1  capture qualifier for this cycle
iw_arm  in  1  pulse: start new capture
iw_abort  in  1  pulse: stop capture, go IDLE
iw_mode  in  1  0=trigger/wrap, 1=one-shot (stop when full)
iw_trig  in  1  external trigger
iw_match_en  in  1  enable compare trigger
iw_trig_val  in  DATA_W  compare value for channel TRIG_CH
iw_post_cnt  in  $clog2(DEPTH)+1  captures after trigger entry, sampled on trigger
iw_rd_en  in  1  read request
iw_rd_idx  in  $clog2(DEPTH)  read index relative to oldest entry
ow_rd_valid  out  1  read data valid (1 cycle after iw_rd_en)
ow_rd_data  out  TICK_W+NCH*DATA_W  {tick, probes}
ow_rd_err  out  1  with ow_rd_valid: idx >= count
ow_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
ow_count  out  $clog2(DEPTH)+1  valid entries, saturates at DEPTH
ow_trig_idx  out  $clog2(DEPTH)  relative index (from oldest) of trigger entry, valid in DONE
ow_done  out  1  state==DONE

Behaviour:
- Reset (async, iw_rst_n=0): state IDLE, tick=0, wr_ptr=0, count=0, all outputs 0. RAM contents not reset. Reset mid-capture discards state immediately.
- Tick: increments every cycle out of reset in all states, wraps modulo 2^TICK_W.
- Entry written = {tick, iw_probe} at wr_ptr. Written only in ARMED/POST with iw_cap_en=1. wr_ptr advances mod DEPTH; count increments saturating at DEPTH.
- IDLE/DONE + iw_arm -> ARMED: wr_ptr=0, count=0. No write in the arm cycle.
- ARMED: trig = iw_trig | (iw_match_en & probe[TRIG_CH]==iw_trig_val), evaluated only when iw_cap_en=1.
  - On trig: the entry is written and its absolute slot is latched. If iw_post_cnt==0 -> DONE; else post counter = iw_post_cnt, -> POST.
  - mode=1: the write that makes count reach DEPTH -> DONE (no wrap). Trigger in the same cycle is still recorded.
  - mode=0: wraps and overwrites the oldest entry.
- POST: each captured entry decrements post counter; the write that brings it to 0 -> DONE. Further triggers are ignored. In mode=0, post captures may overwrite pre-trigger history. If the trigger entry itself is overwritten, ow_trig_idx is undefined (bench must keep post_cnt<DEPTH).
- DONE: no writes; holds until iw_arm or iw_abort.
- iw_abort: any state -> IDLE next cycle, RAM/count retained, readable. Abort beats arm when simultaneous; arm in ARMED/POST is ignored.
- oldest = (count<DEPTH) ? 0 : wr_ptr. Read addr = (oldest + iw_rd_idx) mod DEPTH.
- ow_trig_idx = (trig_slot - oldest) mod DEPTH.
- Read: any state. ow_rd_valid=1 exactly 1 cycle after iw_rd_en; otherwise ow_rd_valid=0 and ow_rd_data holds its last value.
  - Out-of-range read (iw_rd_idx>=count): ow_rd_err=1, ow_rd_data=0.
  - Read of the slot being written in the same cycle returns the new entry (write-first).

Test Plan:
- Reset then 5 idle cycles -> ow_state=0, ow_count=0; read idx 0 -> rd_valid=1, rd_err=1, data 0.
- mode=1, arm at tick 3, cap_en=1 constant, DEPTH=16 -> DONE after 16 writes; entry 0 tick=4, entry 15 tick=19; entry k channel data equals stimulus at tick 4+k.
- mode=0, arm, 30 captures, probe[0]=tick, trig_val=25, post_cnt=3 -> DONE at the write with tick 28; count=16; oldest tick 13; ow_trig_idx=12; entry 15 tick 28.
- cap_en toggled 1/0 every cycle, external trig on a captured cycle, post_cnt=0 -> DONE same cycle; ticks in RAM step by 2; ow_trig_idx=count-1.
- Abort during POST and arm+abort in the same cycle -> IDLE next cycle, count retained, no further writes; later arm -> count=0.
- Assert iw_rst_n=0 mid-POST for a half cycle -> all outputs 0 immediately; tick restarts at 0.

Source files
------------

// File: rtl/diad_trace_buffer.sv
// diad_trace_buffer: on-chip trace capture for the diad pipeline.
// Each qualified capture cycle stores {tick, probe words} into a circular RAM.
// Supports trigger-with-post-count (wrap) and one-shot (stop when full) modes,
// plus a random-access read port indexed relative to the oldest entry.
module diad_trace_buffer #(
    parameter int DATA_W  = 24,
    parameter int NCH     = 7,
    parameter int DEPTH   = 16,
    parameter int TICK_W  = 16,
    parameter int TRIG_CH = 0
) (
    input  logic                              iw_clk,
    input  logic                              iw_rst_n,
    input  logic [NCH*DATA_W-1:0]             iw_probe,
    input  logic                              iw_cap_en,
    input  logic                              iw_arm,
    input  logic                              iw_abort,
    input  logic                              iw_mode,
    input  logic                              iw_trig,
    input  logic                              iw_match_en,
    input  logic [DATA_W-1:0]                 iw_trig_val,
    input  logic [$clog2(DEPTH):0]            iw_post_cnt,
    input  logic                              iw_rd_en,
    input  logic [$clog2(DEPTH)-1:0]          iw_rd_idx,
    output logic                              ow_rd_valid,
    output logic [TICK_W+NCH*DATA_W-1:0]      ow_rd_data,
    output logic                              ow_rd_err,
    output logic [1:0]                        ow_state,
    output logic [$clog2(DEPTH):0]            ow_count,
    output logic [$clog2(DEPTH)-1:0]          ow_trig_idx,
    output logic                              ow_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = TICK_W + NCH * DATA_W;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] DEPTH_M1  = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [TICK_W-1:0]   tick;
    logic [AW-1:0]       wr_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       post;
    logic [AW-1:0]       trig_slot;
    logic [RW-1:0]       mem [DEPTH];

    logic                capturing;
    logic                wr_en;
    logic                trig_hit;
    logic                will_fill;
    logic [AW-1:0]       oldest;
    logic [AW-1:0]       rd_addr;
    logic [RW-1:0]       wr_data;

    // A write happens only while capturing; abort stops capture in its own cycle.
    assign capturing = (state == ARMED) || (state == POST);
    assign wr_en     = capturing && iw_cap_en && !iw_abort;
    assign trig_hit  = iw_trig ||
                       (iw_match_en && (iw_probe[TRIG_CH*DATA_W +: DATA_W] == iw_trig_val));
    assign will_fill = (count == DEPTH_M1);
    assign oldest    = (count == DEPTH_C) ? wr_ptr : '0;
    assign rd_addr   = oldest + iw_rd_idx;
    assign wr_data   = {tick, iw_probe};

    assign ow_state    = state;
    assign ow_count    = count;
    assign ow_done     = (state == DONE);
    assign ow_trig_idx = trig_slot - oldest;

    // Capture control FSM with tick, write pointer, fill count and post counter.
    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            state     <= IDLE;
            tick      <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            post      <= '0;
            trig_slot <= '0;
        end else begin
            tick <= tick + TICK_W'(1);
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                if (count != DEPTH_C) count <= count + CW'(1);
            end
            if (iw_abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (iw_arm) begin
                            state  <= ARMED;
                            wr_ptr <= '0;
                            count  <= '0;
                        end
                    end
                    ARMED: begin
                        if (iw_cap_en) begin
                            if (trig_hit) begin
                                trig_slot <= wr_ptr;
                                if (iw_post_cnt == '0 || (iw_mode && will_fill)) begin
                                    state <= DONE;
                                end else begin
                                    post  <= iw_post_cnt;
                                    state <= POST;
                                end
                            end else if (iw_mode && will_fill) begin
                                state <= DONE;
                            end
                        end
                    end
                    POST: begin
                        if (iw_cap_en) begin
                            post <= post - CW'(1);
                            if (post == CW'(1) || (iw_mode && will_fill)) state <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Trace RAM write port.
    // NOTE: the RAM has no reset so it maps onto block memory; contents stay
    // readable across abort and are simply garbage after power-up.
    always_ff @(posedge iw_clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Registered read port: range check against count, write-first bypass.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            ow_rd_valid <= 1'b0;
            ow_rd_err   <= 1'b0;
            ow_rd_data  <= '0;
        end else begin
            ow_rd_valid <= iw_rd_en;
            if (iw_rd_en) begin
                if ({1'b0, iw_rd_idx} >= count) begin
                    ow_rd_err  <= 1'b1;
                    ow_rd_data <= '0;
                end else begin
                    ow_rd_err  <= 1'b0;
                    ow_rd_data <= (wr_en && (rd_addr == wr_ptr)) ? wr_data : mem[rd_addr];
                end
            end else begin
                ow_rd_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_diad_trace_buffer.sv
// tb_diad_trace_buffer: directed scoreboard bench for diad_trace_buffer.
// Reads push expected {err, data} into a queue; a negedge monitor pops and
// compares whenever the DUT presents ow_rd_valid.
module tb_diad_trace_buffer;

    localparam int DATA_W = 24;
    localparam int NCH    = 7;
    localparam int DEPTH  = 16;
    localparam int TICK_W = 16;
    localparam int AW     = $clog2(DEPTH);
    localparam int CW     = AW + 1;
    localparam int PW     = NCH * DATA_W;
    localparam int RW     = TICK_W + PW;

    typedef struct {
        logic          err;
        logic [RW-1:0] data;
    } rd_exp_t;

    logic              clk;
    logic              rst_n;
    logic [PW-1:0]     probe;
    logic              cap_en, arm, abort, mode, trig, match_en;
    logic [DATA_W-1:0] trig_val;
    logic [CW-1:0]     post_cnt;
    logic              rd_en;
    logic [AW-1:0]     rd_idx;
    logic              rd_valid, rd_err, done;
    logic [RW-1:0]     rd_data;
    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [AW-1:0]     trig_idx;

    int      n_checks = 0;
    int      n_errors = 0;
    int      cyc;
    rd_exp_t exp_q[$];

    diad_trace_buffer #(
        .DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH), .TICK_W(TICK_W), .TRIG_CH(0)
    ) dut (
        .iw_clk(clk), .iw_rst_n(rst_n), .iw_probe(probe), .iw_cap_en(cap_en),
        .iw_arm(arm), .iw_abort(abort), .iw_mode(mode), .iw_trig(trig),
        .iw_match_en(match_en), .iw_trig_val(trig_val), .iw_post_cnt(post_cnt),
        .iw_rd_en(rd_en), .iw_rd_idx(rd_idx), .ow_rd_valid(rd_valid),
        .ow_rd_data(rd_data), .ow_rd_err(rd_err), .ow_state(state),
        .ow_count(count), .ow_trig_idx(trig_idx), .ow_done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tick: value the DUT will stamp at the next rising edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [PW-1:0] mk_probe(int t);
        logic [PW-1:0] p;
        for (int k = 0; k < NCH; k++) p[k*DATA_W +: DATA_W] = {8'(k), 16'(t)};
        return p;
    endfunction

    function automatic logic [RW-1:0] exp_entry(int t);
        return {16'(t), mk_probe(t)};
    endfunction

    task automatic check(string name, logic [RW-1:0] act, logic [RW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every presented read result is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 1, 0);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                check("rd_err", RW'(rd_err), RW'(e.err));
                check("rd_data", rd_data, e.data);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        probe = mk_probe(cyc);
    endtask

    task automatic wait_cyc(int target);
        for (int i = 0; i < 200; i++) begin
            if (cyc == target) return;
            step();
        end
        check("wait_cyc_timeout", RW'(cyc), RW'(target));
    endtask

    task automatic wait_done(string name);
        for (int i = 0; i < 60; i++) begin
            if (done) return;
            step();
        end
        check(name, RW'(done), 1);
    endtask

    task automatic do_read(int idx, logic err, int t);
        rd_exp_t e;
        e.err  = err;
        e.data = err ? '0 : exp_entry(t);
        rd_en  = 1'b1;
        rd_idx = AW'(idx);
        exp_q.push_back(e);
        step();
        rd_en = 1'b0;
        #1;
        check("rd_latency_qdepth", RW'(exp_q.size()), 0);
    endtask

    task automatic clear_inputs();
        cap_en = 0; arm = 0; abort = 0; mode = 0; trig = 0; match_en = 0;
        trig_val = '0; post_cnt = '0; rd_en = 0; rd_idx = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        probe = '0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        probe = mk_probe(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        probe = '0;
        #1;
        // --- Test 1: reset state, idle, out-of-range read
        check("rst_state", RW'(state), 0);
        check("rst_count", RW'(count), 0);
        check("rst_done", RW'(done), 0);
        check("rst_rd_valid", RW'(rd_valid), 0);
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check("idle_state", RW'(state), 0);
        check("idle_count", RW'(count), 0);
        do_read(0, 1'b1, 0);

        // --- Test 2: one-shot, arm at tick 3, 16 writes ticks 4..19
        do_reset();
        wait_cyc(3);
        arm = 1; mode = 1; cap_en = 1;
        step();
        arm = 0;
        check("t2_armed", RW'(state), 1);
        wait_done("t2_done_timeout");
        check("t2_done_cycle", RW'(cyc), 20);
        check("t2_state", RW'(state), 3);
        check("t2_count", RW'(count), 16);
        for (int i = 0; i < 3; i++) step();
        check("t2_no_more_writes", RW'(count), 16);
        do_read(0, 1'b0, 4);
        do_read(15, 1'b0, 19);
        do_read(7, 1'b0, 11);
        step();
        check("t2_hold_valid", RW'(rd_valid), 0);
        check("t2_hold_data", rd_data, exp_entry(11));

        // --- Test 3: wrap mode, match trigger at tick 25, post 3
        do_reset();
        wait_cyc(10);
        arm = 1; mode = 0; cap_en = 1; match_en = 1; trig_val = 25; post_cnt = 3;
        step();
        arm = 0;
        wait_cyc(26);
        check("t3_post", RW'(state), 2);
        step();
        do_read(0, 1'b0, 27);              // write-first on the slot being written
        wait_done("t3_done_timeout");
        check("t3_done_cycle", RW'(cyc), 29);
        check("t3_count", RW'(count), 16);
        check("t3_trig_idx", RW'(trig_idx), 12);
        do_read(0, 1'b0, 13);
        do_read(12, 1'b0, 25);
        do_read(15, 1'b0, 28);

        // --- Test 4: cap_en toggling, external trigger, post_cnt 0
        do_reset();
        wait_cyc(2);
        arm = 1; mode = 0; cap_en = 0; post_cnt = 0;
        step();
        arm = 0;
        while (cyc <= 11) begin
            cap_en = cyc[0];
            trig   = (cyc == 8) || (cyc == 11);
            step();
        end
        cap_en = 0; trig = 0;
        check("t4_state", RW'(state), 3);
        check("t4_count", RW'(count), 5);
        check("t4_trig_idx", RW'(trig_idx), 4);
        for (int k = 0; k < 5; k++) do_read(k, 1'b0, 3 + 2 * k);
        do_read(5, 1'b1, 0);

        // --- Test 5: abort in POST, arm+abort, arm ignored while ARMED
        do_reset();
        wait_cyc(1);
        arm = 1; mode = 0; cap_en = 1; post_cnt = 10;
        step();
        arm = 0;
        wait_cyc(4);
        trig = 1;
        step();
        trig = 0;
        check("t5_post", RW'(state), 2);
        wait_cyc(7);
        abort = 1; cap_en = 0;
        step();
        abort = 0; cap_en = 1;
        check("t5_abort_state", RW'(state), 0);
        check("t5_abort_count", RW'(count), 5);
        for (int i = 0; i < 3; i++) step();
        check("t5_idle_no_write", RW'(count), 5);
        do_read(4, 1'b0, 6);
        do_read(5, 1'b1, 0);
        cap_en = 0; arm = 1; abort = 1;
        step();
        arm = 0; abort = 0;
        check("t5_arm_abort_state", RW'(state), 0);
        check("t5_arm_abort_count", RW'(count), 5);
        arm = 1;
        step();
        arm = 0;
        check("t5_rearm_state", RW'(state), 1);
        check("t5_rearm_count", RW'(count), 0);
        cap_en = 1;
        step();
        step();
        arm = 1;
        step();
        arm = 0; cap_en = 0;
        check("t5_arm_ignored_state", RW'(state), 1);
        check("t5_arm_ignored_count", RW'(count), 3);
        abort = 1;
        step();
        abort = 0;
        check("t5_abort2_state", RW'(state), 0);

        // --- Test 6: async reset mid-POST, tick restarts at 0
        do_reset();
        wait_cyc(2);
        arm = 1; mode = 0; cap_en = 1; post_cnt = 8;
        step();
        arm = 0; trig = 1;
        step();
        trig = 0;
        check("t6_post", RW'(state), 2);
        do_read(0, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", RW'(state), 0);
        check("t6_rst_count", RW'(count), 0);
        check("t6_rst_done", RW'(done), 0);
        check("t6_rst_trig_idx", RW'(trig_idx), 0);
        check("t6_rst_rd_valid", RW'(rd_valid), 0);
        check("t6_rst_rd_err", RW'(rd_err), 0);
        check("t6_rst_rd_data", rd_data, '0);
        clear_inputs();
        #1;
        rst_n = 1'b1;
        step();
        arm = 1; cap_en = 1; post_cnt = 0;
        step();
        arm = 0; trig = 1;
        step();
        trig = 0; cap_en = 0;
        check("t6_done_state", RW'(state), 3);
        check("t6_count", RW'(count), 1);
        do_read(0, 1'b0, 2);

        step();
        check("final_queue_empty", RW'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
